// File: rtl/ssd_scan_ctrl.sv
// Scan controller for the 4-digit seven-segment RGB readout.
// Rotates the digit-select slot at a programmable rate and commits new
// R/G/B nibbles only at a frame boundary or while the display is blanked.
module ssd_scan_ctrl #(
  parameter int unsigned DIV_COUNT = 50000,
  parameter int unsigned CNT_W     = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       upd_valid,
  output logic       upd_ready,
  input  logic [3:0] r_in,
  input  logic [3:0] g_in,
  input  logic [3:0] b_in,
  output logic [1:0] control,
  output logic [3:0] R,
  output logic [3:0] G,
  output logic [3:0] B,
  output logic       frame_done
);

  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DIV_COUNT - 1);

  typedef enum logic [1:0] {
    SLOT_BLANK = 2'b00,
    SLOT_R     = 2'b01,
    SLOT_G     = 2'b10,
    SLOT_B     = 2'b11
  } slot_e;

  slot_e            state_q;
  slot_e            state_d;
  logic [CNT_W-1:0] cnt_q;
  logic [11:0]      hold_q;
  logic             tick_c;
  logic             boundary_c;
  logic             commit_c;
  logic             hs_c;

  // The pending flag is the complement of upd_ready, so ready depends on state only.
  assign tick_c     = en && (cnt_q == CNT_MAX);
  assign boundary_c = tick_c && (state_q == SLOT_B);
  assign hs_c       = upd_valid && upd_ready;
  assign commit_c   = !upd_ready && (!en || boundary_c);
  assign control    = state_q;

  // Prescaler: counts slot length, held at zero while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (!en || tick_c) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  // Slot state register; drives control directly so it is glitch-free.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SLOT_BLANK;
    end else begin
      state_q <= state_d;
    end
  end

  // Slot sequencing: advance on tick, force blank while disabled.
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = SLOT_BLANK;
    end else if (tick_c) begin
      case (state_q)
        SLOT_BLANK: state_d = SLOT_R;
        SLOT_R:     state_d = SLOT_G;
        SLOT_G:     state_d = SLOT_B;
        SLOT_B:     state_d = SLOT_BLANK;
        default:    state_d = SLOT_BLANK;
      endcase
    end
  end

  // Frame boundary pulse, visible the cycle after the 11->00 tick.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      frame_done <= 1'b0;
    end else begin
      frame_done <= boundary_c;
    end
  end

  // Pending buffer and shadow display registers; capture and commit are exclusive.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_q    <= '0;
      upd_ready <= 1'b1;
      R         <= '0;
      G         <= '0;
      B         <= '0;
    end else if (commit_c) begin
      R         <= hold_q[11:8];
      G         <= hold_q[7:4];
      B         <= hold_q[3:0];
      upd_ready <= 1'b1;
    end else if (hs_c) begin
      hold_q    <= {r_in, g_in, b_in};
      upd_ready <= 1'b0;
    end
  end

endmodule

// File: tb/tb_ssd_scan_ctrl.sv
// Self-checking bench for ssd_scan_ctrl: directed vector tables, a reset
// sequence, and randomized traffic against a cycle-count reference model.
module tb_ssd_scan_ctrl;

  localparam int unsigned D  = 4;
  localparam int unsigned CW = 3;

  logic       clk;
  logic       rst_n;
  logic       en;
  logic       upd_valid;
  logic       upd_ready;
  logic [3:0] r_in, g_in, b_in;
  logic [1:0] control;
  logic [3:0] R, G, B;
  logic       frame_done;

  int checks;
  int errors;

  typedef struct {
    logic        en;
    logic        valid;
    logic [11:0] din;
    logic [1:0]  ctl;
    logic [11:0] rgb;
    logic        rdy;
    logic        fd;
  } vec_t;

  vec_t tbl[64];
  int   tbl_n;

  ssd_scan_ctrl #(.DIV_COUNT(D), .CNT_W(CW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .en         (en),
    .upd_valid  (upd_valid),
    .upd_ready  (upd_ready),
    .r_in       (r_in),
    .g_in       (g_in),
    .b_in       (b_in),
    .control    (control),
    .R          (R),
    .G          (G),
    .B          (B),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input int cyc, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
    end
  endtask

  task automatic drive(input logic e, input logic v, input logic [11:0] d);
    en        = e;
    upd_valid = v;
    r_in      = d[11:8];
    g_in      = d[7:4];
    b_in      = d[3:0];
  endtask

  // Leaves the bench 1ns into cycle 0 (first edge after reset release).
  task automatic do_reset();
    rst_n = 1'b0;
    drive(1'b0, 1'b0, 12'h000);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic run_table(input string tag);
    for (int i = 0; i < tbl_n; i++) begin
      drive(tbl[i].en, tbl[i].valid, tbl[i].din);
      @(negedge clk);
      chk({tag, "_control"},    i, 16'(control),    16'(tbl[i].ctl));
      chk({tag, "_rgb"},        i, 16'({R, G, B}),  16'(tbl[i].rgb));
      chk({tag, "_upd_ready"},  i, 16'(upd_ready),  16'(tbl[i].rdy));
      chk({tag, "_frame_done"}, i, 16'(frame_done), 16'(tbl[i].fd));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    checks = 0;
    errors = 0;

    // Rotation, update and backpressure in one frame pair.
    tbl_n = 34;
    for (int c = 0; c < 34; c++) begin
      tbl[c].en    = 1'b1;
      tbl[c].valid = (c == 2) || (c >= 5 && c <= 16);
      tbl[c].din   = (c == 2) ? 12'h5A3 : 12'h777;
      tbl[c].ctl   = 2'((c / 4) % 4);
      tbl[c].rgb   = (c < 16) ? 12'h000 : (c < 32) ? 12'h5A3 : 12'h777;
      tbl[c].rdy   = (c < 3) || (c == 16) || (c >= 32);
      tbl[c].fd    = (c == 16) || (c == 32);
    end
    do_reset();
    run_table("rot");

    // Disable mid-frame with a triple pending, re-enable at cycle 20.
    tbl_n = 26;
    for (int c = 0; c < 26; c++) begin
      tbl[c].en    = !(c >= 9 && c <= 19);
      tbl[c].valid = (c == 2);
      tbl[c].din   = 12'h5A3;
      tbl[c].ctl   = (c < 4) ? 2'd0 : (c < 8) ? 2'd1 : (c < 10) ? 2'd2 : (c < 24) ? 2'd0 : 2'd1;
      tbl[c].rgb   = (c < 10) ? 12'h000 : 12'h5A3;
      tbl[c].rdy   = (c < 3) || (c >= 10);
      tbl[c].fd    = 1'b0;
    end
    do_reset();
    run_table("dis");

    // Handshake on the boundary tick commits one frame later.
    tbl_n = 34;
    for (int c = 0; c < 34; c++) begin
      tbl[c].en    = 1'b1;
      tbl[c].valid = (c == 15);
      tbl[c].din   = 12'h123;
      tbl[c].ctl   = 2'((c / 4) % 4);
      tbl[c].rgb   = (c < 32) ? 12'h000 : 12'h123;
      tbl[c].rdy   = (c < 16) || (c >= 32);
      tbl[c].fd    = (c == 16) || (c == 32);
    end
    do_reset();
    run_table("col");

    // Randomized traffic against a cycle-count model.
    begin
      int          run;
      logic        m_pend;
      logic [11:0] m_hold;
      logic [11:0] m_disp;
      logic        m_fd;
      logic        e, v, bnd;
      logic [11:0] d;
      run = 0; m_pend = 1'b0; m_hold = '0; m_disp = '0; m_fd = 1'b0;
      do_reset();
      for (int c = 0; c < 4000; c++) begin
        e = ($urandom_range(0, 79) != 0);
        v = ($urandom_range(0, 3) == 0);
        d = 12'($urandom);
        drive(e, v, d);
        @(negedge clk);
        chk("rnd_control",    c, 16'(control),    16'((run / D) % 4));
        chk("rnd_rgb",        c, 16'({R, G, B}),  16'(m_disp));
        chk("rnd_upd_ready",  c, 16'(upd_ready),  16'(!m_pend));
        chk("rnd_frame_done", c, 16'(frame_done), 16'(m_fd));
        bnd  = e && ((run % (4 * D)) == (4 * D - 1));
        m_fd = bnd;
        if (m_pend && (!e || bnd)) begin
          m_disp = m_hold;
          m_pend = 1'b0;
        end else if (v && !m_pend) begin
          m_hold = d;
          m_pend = 1'b1;
        end
        run = e ? run + 1 : 0;
        @(posedge clk);
        #1;
      end
    end

    // Asynchronous reset mid-count with a triple pending.
    do_reset();
    for (int c = 0; c < 23; c++) begin
      drive(1'b1, (c == 0) || (c == 17), (c == 0) ? 12'hABC : 12'h111);
      @(negedge clk);
      if (c == 21) begin
        chk("pre_rst_rgb",     c, 16'({R, G, B}), 16'h0ABC);
        chk("pre_rst_ready",   c, 16'(upd_ready), 16'h0000);
        chk("pre_rst_control", c, 16'(control),   16'h0001);
      end
      @(posedge clk);
      #1;
    end
    #2;
    rst_n = 1'b0;
    #1;
    chk("async_rst_control", 23, 16'(control),    16'h0000);
    chk("async_rst_rgb",     23, 16'({R, G, B}),  16'h0000);
    chk("async_rst_ready",   23, 16'(upd_ready),  16'h0001);
    chk("async_rst_fd",      23, 16'(frame_done), 16'h0000);
    drive(1'b0, 1'b0, 12'h000);
    #3;
    rst_n = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_discard_rgb",   25, 16'({R, G, B}), 16'h0000);
    chk("rst_discard_ready", 25, 16'(upd_ready), 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/ssd_scan_ctrl.md
# ssd_scan_ctrl

Scan controller for the 4-digit seven-segment RGB readout. It generates the 2-bit `control` digit-select sequence consumed by the SSD scan multiplexer, and advances it at a programmable refresh rate. It holds the displayed R/G/B nibbles in shadow registers and accepts new values through a valid/ready handshake. New values are committed only at a frame boundary, so the display never tears. It sits between the colour-generation logic (upstream) and the scan mux / segment decoder (downstream).

## Interface
Parameters:
- `DIV_COUNT`, default 50000: clock cycles per digit slot. Legal range is ≥ 2.
- `CNT_W`, default 16: prescaler width. Must satisfy 2^CNT_W ≥ DIV_COUNT.

Ports:
- `clk`  in  1  system clock, all logic on rising edge
- `rst_n`  in  1  reset, asynchronous, active-low
- `en`  in  1  scan enable; low forces blank slot
- `upd_valid`  in  1  upstream offers new R/G/B triple
- `upd_ready`  out  1  controller can accept a triple
- `r_in`, `g_in`, `b_in`  in  4 each  offered nibbles, sampled on handshake
- `control`  out  2  digit slot to scan mux: 00 blank, 01 R, 10 G, 11 B
- `R`, `G`, `B`  out  4 each  committed display nibbles
- `frame_done`  out  1  one-cycle pulse at each frame boundary

## Operation
- Prescaler `cnt` counts 0..DIV_COUNT-1 while `en`=1.
  - `tick` = (`cnt`==DIV_COUNT-1) && `en`. On `tick`, `cnt` wraps to 0.
- Slot register drives `control` directly; `control` is registered and glitch-free.
  - Slot sequence on each `tick`: 00→01→10→11→00.
  - Slot 00 is the blank/commit window.
- Frame boundary is the `tick` with `control`==11 (11→00 transition).
  - On that cycle, `frame_done` is registered high for exactly one cycle (visible the following cycle).
- Pending buffer: a 12-bit holding register plus a `pend` flag.
  - `upd_ready` = ~`pend`, registered-equivalent (depends on state only, not on `upd_valid`).
  - Handshake occurs when `upd_valid` && `upd_ready` at a rising edge: capture {`r_in`,`g_in`,`b_in`} and set `pend`.
  - Commit (frame boundary or disabled, see below) with `pend`=1: copy the buffer to `R`/`G`/`B` and clear `pend`.
  - Handshake on the same cycle as a boundary, with `pend`=0: capture only. The commit happens at the next boundary, never same-cycle.
  - `upd_valid` while `pend`=1: ignored; upstream must hold its data until `upd_ready`.
- `en`=0:
  - `cnt` and slot are synchronously forced to 0, so `control`=00 from the next edge.
  - No `frame_done`.
  - A pending triple commits on the next edge, since the display is blank.
  - Handshakes are still accepted.
- Re-enable: counting restarts from `cnt`=0 in slot 00. The first transition to 01 occurs DIV_COUNT cycles after `en` rises.
- Reset (`rst_n`=0, any time, asynchronous): `cnt`=0, `control`=00, `R`=`G`=`B`=0, `pend`=0, `upd_ready`=1, `frame_done`=0. A mid-frame reset discards the pending triple.

## Timing
- One frame = 4×DIV_COUNT cycles. Each slot persists exactly DIV_COUNT cycles.
- Handshake to commit latency: from 1 cycle (`en`=0) up to one full frame (`en`=1).
- `R`/`G`/`B` change only on the edge where `control` goes 11→00, or on an edge while `en`=0. They never change while `control` shows 01/10/11.
- `upd_ready` rises on the same edge that commits.
- Maximum update throughput is one triple per frame.

## Test plan
- Reset: assert `rst_n`=0 mid-count with `pend`=1 → all outputs return to their reset values immediately, without waiting for a clock edge; `upd_ready`=1 and `control`=00.
- Rotation, DIV_COUNT=4, `en`=1 from cycle 0:
  - `control`=00 on cycles 0–3, 01 on 4–7, 10 on 8–11, 11 on 12–15, then 00 from cycle 16.
  - `frame_done` high only on cycle 16.
- Update:
  - Stimulus: `upd_valid` on cycle 2 with `r_in`=5, `g_in`=A, `b_in`=3.
  - Required response: `upd_ready`=0 from cycle 3; `R`/`G`/`B` stay 0/0/0 through cycle 15; `R`/`G`/`B` become 5/A/3 and `upd_ready`=1 on cycle 16.
- Backpressure:
  - Stimulus: second `upd_valid` with 7/7/7 at cycle 5, held asserted.
  - Required response: ignored until cycle 16; captured at cycle 16 and committed at cycle 32.
- Disable mid-frame:
  - Stimulus: drop `en` at cycle 9 with a triple pending.
  - Required response: `control`=00 from cycle 10; triple committed at cycle 10; no `frame_done`.
  - On re-enable at cycle 20, `control` becomes 01 at cycle 24.
- Boundary collision:
  - Stimulus: handshake exactly on cycle 15 (the 11→00 tick) with `pend`=0.
  - Required response: no commit at cycle 16; commit at cycle 32.
